// File: rtl/mips_data_bus_pkg.sv
// mips_data_bus_pkg: bus FSM states and the error read-data pattern
package mips_data_bus_pkg;
   typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_DONE} bus_state_e;
   localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mips_data_bus_watchdog.sv
// mips_data_bus_watchdog: counts WAIT cycles and flags the cycle an access hits its limit
module mips_data_bus_watchdog (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_clear,
   input  logic       i_enable,
   input  logic [7:0] i_limit,
   output logic       o_expired
);
   logic [7:0] r_count;
   // cleared at launch, advances once per WAIT cycle
   always_ff @(posedge i_clock)
      if (!i_reset || i_clear) r_count <= '0;
      else if (i_enable) r_count <= r_count + 8'd1;
   assign o_expired = i_enable && ({1'b0, r_count} + 9'd1 >= {1'b0, i_limit});
endmodule

// File: rtl/mips_data_bus.sv
// mips_data_bus: stalling load/store interconnect from the core to memory-mapped slaves
module mips_data_bus
   import mips_data_bus_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int SEL_LSB    = 12,
   parameter int TIMEOUT    = 15
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_cpu_req,
   input  logic                         i_cpu_we,
   input  logic [ADDR_W-1:0]            i_cpu_addr,
   input  logic [DATA_W-1:0]            i_cpu_wd,
   output logic [DATA_W-1:0]            o_cpu_rd,
   output logic                         o_cpu_stall,
   output logic                         o_cpu_err,
   output logic [7:0]                   o_err_count,
   output logic [NUM_SLAVES-1:0]        o_s_req,
   output logic                         o_s_we,
   output logic [ADDR_W-1:0]            o_s_addr,
   output logic [DATA_W-1:0]            o_s_wd,
   input  logic [NUM_SLAVES*DATA_W-1:0] i_s_rd,
   input  logic [NUM_SLAVES-1:0]        i_s_ack
);
   localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
   bus_state_e r_state, w_next;
   logic [SEL_W-1:0] r_sel, w_sel;
   logic [NUM_SLAVES-1:0] r_req;
   logic r_we, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wd, r_rd, w_rd;
   logic [7:0] r_err_count;
   logic w_mapped, w_launch, w_ack, w_expired, w_finish;
   assign w_sel = i_cpu_addr[SEL_LSB +: SEL_W];
   assign w_mapped = {1'b0, w_sel} < (SEL_W + 1)'(NUM_SLAVES);
   assign w_launch = r_state == BUS_IDLE && i_cpu_req;
   assign w_finish = r_state == BUS_WAIT && (w_ack || w_expired);
   mips_data_bus_watchdog u_watchdog (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_launch),
      .i_enable (r_state == BUS_WAIT),
      .i_limit  (8'(TIMEOUT)),
      .o_expired(w_expired)
   );
   // only the latched slave's ack and read slice are visible; other ports are ignored
   always_comb begin
      w_ack = 1'b0;
      w_rd = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (r_sel == SEL_W'(i)) begin
            w_ack = i_s_ack[i];
            w_rd = i_s_rd[i*DATA_W +: DATA_W];
         end
   end
   // next state: unmapped addresses skip WAIT, and an ack beats a same-cycle timeout
   always_comb begin
      w_next = r_state;
      if (w_launch) w_next = w_mapped ? BUS_WAIT : BUS_DONE;
      else if (w_finish) w_next = BUS_DONE;
      else if (r_state == BUS_DONE) w_next = BUS_IDLE;
   end
   // state register
   always_ff @(posedge i_clock)
      r_state <= !i_reset ? BUS_IDLE : w_next;
   // latch the access at launch and capture its response on completion
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_sel <= '0;
         r_req <= '0;
         r_we <= 1'b0;
         r_addr <= '0;
         r_wd <= '0;
         r_rd <= '0;
         r_err <= 1'b0;
      end else if (w_launch) begin
         r_sel <= w_sel;
         r_we <= i_cpu_we;
         r_addr <= i_cpu_addr;
         r_wd <= i_cpu_wd;
         r_req <= w_mapped ? NUM_SLAVES'(1) << w_sel : '0;
         if (!w_mapped) begin
            r_rd <= DATA_W'(BUS_ERR_DATA);
            r_err <= 1'b1;
         end
      end else if (w_finish) begin
         r_req <= '0;
         r_rd <= w_ack ? w_rd : DATA_W'(BUS_ERR_DATA);
         r_err <= !w_ack;
      end
   end
   // saturating count of accesses that end in an error
   always_ff @(posedge i_clock)
      if (!i_reset) r_err_count <= '0;
      else if (((w_launch && !w_mapped) || (w_finish && !w_ack)) && r_err_count != 8'hFF)
         r_err_count <= r_err_count + 8'd1;
   assign o_cpu_stall = i_cpu_req && r_state != BUS_DONE;
   assign o_cpu_rd = r_rd;
   assign o_cpu_err = r_err;
   assign o_err_count = r_err_count;
   assign o_s_req = r_req;
   assign o_s_we = r_we;
   assign o_s_addr = r_addr;
   assign o_s_wd = r_wd;
endmodule
